gpio_btn_reader: RTL
====================

Name: gpio_btn_reader

Overview:
- Input-side GPIO block; the receive counterpart of the LED output GPIO.
- Reads asynchronous push-button/switch pins, synchronises and debounces them, detects rising edges, and queues one sticky event per pin.
- Events are handed to the accelerator control FSM over a valid/ready port, e.g. as start/abort commands.

Parameters:
- NUM_IN, 4, number of input pins (1..8).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a new level (>=2).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; do not override).
- ID_W, max(1,$clog2(NUM_IN)), event index width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- btn_in  in  NUM_IN  raw asynchronous pins.
- level_out  out  NUM_IN  debounced level per pin.
- rise_pulse  out  NUM_IN  one-cycle pulse on accepted 0->1.
- fall_pulse  out  NUM_IN  one-cycle pulse on accepted 1->0 (tied 0 unless feature enabled).
- event_valid  out  1  at least one event pending.
- event_id  out  ID_W  index of the served event.
- event_fall  out  1  served event is a falling edge (tied 0 unless feature enabled).
- event_ready  in  1  consumer accepts the event.
- ovf  out  NUM_IN  sticky flag: edge arrived while the same event was still pending.
- ovf_clr  in  1  clears all ovf bits.

Behaviour:
- Reset (sync, active-high): all sync flops, stable levels, counters, pulses, pending and ovf cleared to 0. All outputs are 0. A reset mid-debounce or with events pending discards everything.
- Synchroniser: 2 flops per pin (s1, s2). Never use btn_in combinationally.
- Debounce, per pin:
  - If s2 == stable, clear cnt.
  - Otherwise cnt increments each clock.
  - On the edge where cnt would reach DEBOUNCE_CYCLES, stable <= s2 and cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes stable.
- Latency: a level settled before clock edge E appears on level_out after edge E+1+DEBOUNCE_CYCLES.
- Pulses: rise_pulse/fall_pulse are registered and high for exactly the first cycle level_out shows the new value.
- Pending:
  - Bit set on the same edge rise_pulse is registered, so event_valid can rise in the same cycle as rise_pulse.
  - event_valid = |pending.
  - event_id = lowest-index pending bit (fixed priority, combinational from registered pending).
  - Handshake: on valid && ready at an edge, clear pending[event_id].
  - event_id/event_fall stay stable while valid && !ready. Lower-index newcomers may pre-empt only in the cycle after a transfer, never while valid && !ready.
  - Implement this with a registered "hold" index latched whenever valid && !ready.
- Simultaneous clear and new edge on the same bit: set wins; the bit stays pending and ovf is not set.
- Overflow: a new edge on a bit already pending (and not cleared that edge) sets ovf[bit]. ovf_clr clears all bits; a set in the same cycle as ovf_clr wins.
- No combinational path from event_ready to event_valid/event_id.

Optional Feature:
- Macro: GPIO_FALL_EVT_EN.
- Defined:
  - Separate pending_fall vector; falling edges queue events.
  - Priority order is rise[0], fall[0], rise[1], fall[1], ...
  - event_fall marks falling events; fall_pulse is active.
  - ovf covers both edge types per pin.
- Undefined:
  - fall_pulse = 0, event_fall = 0.
  - No pending_fall flops.
  - Falling edges only update level_out.

Decomposition:
- Package gpio_pkg:
  - GPIO_MAX_IN = 8.
  - Default DEBOUNCE_CYCLES.
  - Edge-type enum {EDGE_RISE, EDGE_FALL}.
  - Shared with the LED output block.
- Sub-module gpio_debounce:
  - One pin: sync flops, counter, stable, rise/fall pulses.
  - Instantiated NUM_IN times by generate.
- Top holds pending/ovf/arbiter.

Test Plan (NUM_IN=4, DEBOUNCE_CYCLES=4):
- Reset: hold rst with btn_in=4'hF -> all outputs 0. After release and a settled 4'h0, no event_valid for 20 cycles.
- Press pin 2 (btn_in=4'h4), held -> level_out=4'h4 exactly 5 edges later. rise_pulse=4'h4 for one cycle; event_valid=1, event_id=2. ready=1 -> valid drops next cycle.
- Glitch: pin 1 high for 3 cycles then low -> level_out, rise_pulse and event_valid remain 0.
- Priority/hold:
  - Pins 3 and 1 pending, ready=0 -> event_id=1 held.
  - Pin 0 rises while held -> id stays 1.
  - After the transfer, next id=0, then id=3.
- Overflow: pin 0 press, release, press with ready=0 -> ovf=4'h1, pending still single. ovf_clr -> ovf=0.
- Mid-operation reset: rst asserted mid-debounce with events pending -> next cycle all outputs 0. With GPIO_FALL_EVT_EN, a release of pin 2 -> event_id=2, event_fall=1.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: definitions shared by the GPIO input (button reader) and
// GPIO output (LED) blocks.
//   GPIO_MAX_IN            - upper bound on pins per GPIO block
//   GPIO_DEBOUNCE_DEFAULT  - default debounce length in clock cycles
//   edge_e                 - edge type; also the slot index of an edge
//                            event inside a per-pin event group
package gpio_pkg;

  localparam int unsigned GPIO_MAX_IN           = 8;
  localparam int unsigned GPIO_DEBOUNCE_DEFAULT = 16;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_e;

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: single-pin synchroniser, debouncer and edge detector.
//   clk, rst    - system clock, synchronous active-high reset
//   pin         - raw asynchronous input
//   level       - debounced level
//   rise_pulse  - registered one-cycle pulse on an accepted 0->1
//   fall_pulse  - registered one-cycle pulse on an accepted 1->0
//                 (held at 0 when SLOTS == 1)
//   evt_set     - combinational "edge accepted this cycle" per event slot,
//                 indexed by edge_e; only the rise slot exists when SLOTS == 1
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int unsigned SLOTS           = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin,
  output logic             level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [SLOTS-1:0] evt_set
);

  localparam bit FALL_EN = (SLOTS > 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             rise_d;
  logic             fall_d;

  // The counter has seen DEBOUNCE_CYCLES-1 differing samples; the current
  // differing sample is the last one needed.
  assign accept = (s2 != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise_d = accept && s2;
  assign fall_d = accept && !s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      stable     <= 1'b0;
      cnt        <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      rise_pulse <= rise_d;
      fall_pulse <= FALL_EN && fall_d;
    end
  end

  assign level             = stable;
  assign evt_set[EDGE_RISE] = rise_d;

  if (FALL_EN) begin : g_fall
    assign evt_set[EDGE_FALL] = fall_d;
  end

endmodule

// File: rtl/gpio_btn_reader.sv
// gpio_btn_reader: push-button / switch input block. Debounces NUM_IN pins,
// queues one sticky event per pin edge and serves them over valid/ready.
//   clk, rst     - system clock, synchronous active-high reset
//   btn_in       - raw asynchronous pins
//   level_out    - debounced levels
//   rise_pulse   - one-cycle pulse per pin on an accepted 0->1
//   fall_pulse   - one-cycle pulse per pin on an accepted 1->0 (0 unless
//                  GPIO_FALL_EVT_EN)
//   event_valid  - at least one event pending
//   event_id     - pin index of the served event
//   event_fall   - served event is a falling edge (0 unless GPIO_FALL_EVT_EN)
//   event_ready  - consumer accepts the served event
//   ovf          - sticky per pin: edge arrived while its event was pending
//   ovf_clr      - clears all ovf bits
// Build option: define GPIO_FALL_EVT_EN to also queue falling-edge events.
module gpio_btn_reader
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_IN          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int unsigned ID_W            = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] btn_in,
  output logic [NUM_IN-1:0] level_out,
  output logic [NUM_IN-1:0] rise_pulse,
  output logic [NUM_IN-1:0] fall_pulse,
  output logic              event_valid,
  output logic [ID_W-1:0]   event_id,
  output logic              event_fall,
  input  logic              event_ready,
  output logic [NUM_IN-1:0] ovf,
  input  logic              ovf_clr
);

`ifdef GPIO_FALL_EVT_EN
  localparam int unsigned SLOTS = 2;
`else
  localparam int unsigned SLOTS = 1;
`endif
  // Events are slotted per pin as {fall, rise}, so ascending slot index is
  // the priority order rise[0], fall[0], rise[1], ... With the fall feature
  // the odd slots of ev_pend are the falling-edge pending bits.
  localparam int unsigned EV_N  = NUM_IN * SLOTS;
  localparam int unsigned SEL_W = (EV_N > 1) ? $clog2(EV_N) : 1;

  logic [EV_N-1:0]   ev_set;
  logic [EV_N-1:0]   ev_pend;
  logic [EV_N-1:0]   ev_clr;
  logic [NUM_IN-1:0] ovf_hit;
  logic [SEL_W-1:0]  arb_sel;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  hold_sel;
  logic              hold_vld;
  logic              found;
  logic              xfer;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_pin
    gpio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .SLOTS           (SLOTS)
    ) u_deb (
      .clk        (clk),
      .rst        (rst),
      .pin        (btn_in[i]),
      .level      (level_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .evt_set    (ev_set[i*SLOTS +: SLOTS])
    );
  end

  always_comb begin
    arb_sel = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < EV_N; i++) begin
      if (!found && ev_pend[i]) begin
        arb_sel = SEL_W'(i);
        found   = 1'b1;
      end
    end
  end

  // A stalled event keeps its slot even if a higher-priority one arrives.
  assign sel         = hold_vld ? hold_sel : arb_sel;
  assign event_valid = |ev_pend;
  assign event_id    = ID_W'(sel >> (SLOTS - 1));
`ifdef GPIO_FALL_EVT_EN
  assign event_fall  = (edge_e'(sel[0]) == EDGE_FALL);
`else
  assign event_fall  = 1'b0;
`endif
  assign xfer        = event_valid && event_ready;

  always_comb begin
    ev_clr  = '0;
    ovf_hit = '0;
    for (int unsigned i = 0; i < EV_N; i++) begin
      ev_clr[i] = xfer && (sel == SEL_W'(i));
    end
    // A same-edge clear frees the slot, so the new edge is not an overflow.
    for (int unsigned p = 0; p < NUM_IN; p++) begin
      for (int unsigned s = 0; s < SLOTS; s++) begin
        ovf_hit[p] = ovf_hit[p] |
                     (ev_set[p*SLOTS+s] & ev_pend[p*SLOTS+s] & ~ev_clr[p*SLOTS+s]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_pend  <= '0;
      ovf      <= '0;
      hold_vld <= 1'b0;
      hold_sel <= '0;
    end else begin
      ev_pend  <= ev_set | (ev_pend & ~ev_clr);
      ovf      <= ovf_hit | (ovf & ~{NUM_IN{ovf_clr}});
      hold_vld <= event_valid && !event_ready;
      hold_sel <= sel;
    end
  end

endmodule
